operand_pair_loader: RTL and testbench
======================================

# operand_pair_loader

Byte-serial front end for the 8-bit adder stage. Accepts a stream of bytes over a valid/ready handshake, pairs them in arrival order (first byte is operand A, second is operand B) and presents each registered pair to the adder with its own valid/ready handshake. It also keeps a running count of pairs delivered. It sits directly upstream of the adder: `op_a` drives the adder's A operand and `op_b` drives its B operand.

## Interface
Parameters
- `WIDTH`, default 8: operand/byte width. The adder stage fixes it at 8.
- `CNT_W`, default 8: width of `pair_count`.

Ports
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `flush`, input, 1: synchronous abort; discards any partial or held pair.
- `in_data`, input, WIDTH: incoming byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader accepts `in_data` this cycle.
- `op_a`, output, WIDTH: operand A to the adder, registered.
- `op_b`, output, WIDTH: operand B to the adder, registered.
- `op_valid`, output, 1: `op_a`/`op_b` hold a complete pair.
- `op_ready`, input, 1: consumer takes the pair this cycle.
- `pair_count`, output, CNT_W: number of pairs delivered, modulo 2^CNT_W.

## Operation
- Reset (`rst`=1): state LOAD_A; `op_a`=0, `op_b`=0, `op_valid`=0, `pair_count`=0, `in_ready`=0.
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `op_valid && op_ready`.
- The FSM has three states.
  - LOAD_A: `in_ready`=1, `op_valid`=0. On an input transfer: `op_a`<=`in_data`, go to LOAD_B.
  - LOAD_B: `in_ready`=1, `op_valid`=0. On an input transfer: `op_b`<=`in_data`, go to HOLD.
  - HOLD: `op_valid`=1, and `in_ready`=`op_ready` (combinational).
    - `op_ready`=1 and `in_valid`=1: the pair is delivered, `op_a`<=`in_data`, go to LOAD_B (back-to-back operation).
    - `op_ready`=1 and `in_valid`=0: the pair is delivered, go to LOAD_A.
    - `op_ready`=0: stay in HOLD. `op_a`, `op_b` and `op_valid` hold stable until the pair is taken.
- `op_b` is not modified in LOAD_A or in LOAD_B before the second byte is captured. The consumer must only sample while `op_valid`=1.
- `flush`=1 overrides everything except `rst`:
  - `in_ready` is forced to 0, so no byte is accepted.
  - An output transfer in the same cycle is not counted.
  - Next state is LOAD_A and `op_valid`=0 from the next cycle.
  - `op_a`/`op_b` keep their values; `pair_count` is unchanged.
- `pair_count` increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-pair or mid-hold: outputs clear immediately (asynchronously) and the partial pair is lost. After release, the first accepted byte is A.

## Timing
- `in_ready` and `op_valid` are pure functions of the state (plus `op_ready` and `flush` for `in_ready`). There is no combinational path from `in_data` or `in_valid` to any output.
- Latency: first byte accepted in cycle N, second in cycle N+1, `op_valid`=1 from cycle N+2.
- Peak throughput: one pair per 2 cycles. Sustained when `op_ready`=1 and `in_valid` is held high, via the HOLD->LOAD_B path.
- `pair_count` updates the cycle after the output transfer.
- `rst` deassertion must be synchronous to `clk` (external synchroniser). The first input transfer can occur on the first rising edge after release.

## Test plan
- Reset: drive `rst`=1 with arbitrary inputs. Required: `op_a`=0, `op_b`=0, `op_valid`=0, `in_ready`=0, `pair_count`=0; after release `in_ready`=1.
- Single pair: send 0x12 then 0x34 with `op_ready`=1. Required: `op_valid` high for exactly 1 cycle with `op_a`=0x12, `op_b`=0x34; then `pair_count`=1.
- Backpressure: send 0xFF, 0x01 with `op_ready`=0 for 5 cycles, while offering 0xAA. Required: `op_a`/`op_b` stable at 0xFF/0x01, `in_ready`=0, 0xAA not accepted until `op_ready`=1. 0xAA is then accepted in the delivery cycle and becomes the next `op_a`.
- Streaming: send 0x00..0x09 back-to-back with `op_ready`=1. Required: 5 pairs (0x00,0x01)…(0x08,0x09), one every 2 cycles, `pair_count`=5.
- Flush mid-pair: send 0x55, pulse `flush` while 0x66 is offered, then send 0x77, 0x88. Required: 0x66 dropped; next pair is `op_a`=0x77, `op_b`=0x88; `pair_count` unchanged by the flush.
- Wrap and async reset: deliver 256 pairs. Required: `pair_count` reads 0. Then assert `rst` while in HOLD; required: `op_valid` drops in the same cycle without a clock edge.

Source files
------------

// File: rtl/operand_pair_loader.sv
// Byte-serial operand loader: pairs incoming bytes into (A, B) operands and
// hands each registered pair to the adder stage over a valid/ready handshake.
module operand_pair_loader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [CNT_W-1:0] pair_count
);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [CNT_W-1:0] r_pair_count;
  logic             w_in_ready;
  logic             w_op_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_a;
  logic             w_load_b;

  // Handshake outputs depend only on state, op_ready, flush and reset.
  always_comb begin
    w_in_ready = 1'b0;
    w_op_valid = 1'b0;
    case (r_state)
      S_LOAD_A: w_in_ready = 1'b1;
      S_LOAD_B: w_in_ready = 1'b1;
      S_HOLD: begin
        w_op_valid = 1'b1;
        w_in_ready = op_ready;
      end
      default: begin
        w_in_ready = 1'b0;
        w_op_valid = 1'b0;
      end
    endcase
    if (rst || flush) begin
      w_in_ready = 1'b0;
    end else begin
      w_in_ready = w_in_ready;
    end
  end

  assign w_in_xfer  = in_valid & w_in_ready;
  // A transfer coinciding with flush is discarded and not counted.
  assign w_out_xfer = w_op_valid & op_ready & ~flush;
  assign w_load_a   = w_in_xfer & ((r_state == S_LOAD_A) | (r_state == S_HOLD));
  assign w_load_b   = w_in_xfer & (r_state == S_LOAD_B);

  // Next-state selection; flush always returns to LOAD_A.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_LOAD_A;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          if (w_in_xfer) w_next_state = S_LOAD_B;
          else           w_next_state = S_LOAD_A;
        end
        S_LOAD_B: begin
          if (w_in_xfer) w_next_state = S_HOLD;
          else           w_next_state = S_LOAD_B;
        end
        S_HOLD: begin
          if (!op_ready)     w_next_state = S_HOLD;
          else if (in_valid) w_next_state = S_LOAD_B;
          else               w_next_state = S_LOAD_A;
        end
        default: w_next_state = S_LOAD_A;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture; op_b only changes when the second byte arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a <= {WIDTH{1'b0}};
      r_op_b <= {WIDTH{1'b0}};
    end else begin
      if (w_load_a) begin
        r_op_a <= in_data;
      end
      if (w_load_b) begin
        r_op_b <= in_data;
      end
    end
  end

  // Delivered-pair counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair_count <= {CNT_W{1'b0}};
    end else if (w_out_xfer) begin
      r_pair_count <= r_pair_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = w_in_ready;
  assign op_valid   = w_op_valid;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign pair_count = r_pair_count;

endmodule

// File: tb/tb_operand_pair_loader.sv
// Directed bench for operand_pair_loader: expected pairs are queued as
// stimulus is issued and a negedge monitor checks each delivered pair.
module tb_operand_pair_loader;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] pair_count;

  int tests;
  int failed;
  logic [15:0] exp_q[$];

  operand_pair_loader #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .pair_count(pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output pair must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && !flush && op_valid && op_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL pair_unexpected: got a=0x%0h b=0x%0h, expected no pair", op_a, op_b);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({op_a, op_b} !== e) begin
          failed++;
          $display("FAIL pair: got a=0x%0h b=0x%0h, expected a=0x%0h b=0x%0h",
                   op_a, op_b, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1; flush = 1'b0; in_data = 8'h5A; in_valid = 1'b1; op_ready = 1'b1;

    // Reset with arbitrary inputs
    step(); step();
    check("rst_op_a", op_a, 32'h0);
    check("rst_op_b", op_b, 32'h0);
    check("rst_op_valid", op_valid, 32'h0);
    check("rst_in_ready", in_ready, 32'h0);
    check("rst_pair_count", pair_count, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 32'h1);

    // Single pair
    exp_q.push_back(16'h1234);
    in_valid = 1'b1; in_data = 8'h12; step();
    in_data = 8'h34; step();
    in_valid = 1'b0;
    check("single_valid", op_valid, 32'h1);
    step();
    check("single_valid_one_cycle", op_valid, 32'h0);
    check("single_count", pair_count, 32'h1);

    // Backpressure while 0xAA is offered
    op_ready = 1'b0;
    exp_q.push_back(16'hFF01);
    in_valid = 1'b1; in_data = 8'hFF; step();
    in_data = 8'h01; step();
    in_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      check("bp_op_a", op_a, 32'hFF);
      check("bp_op_b", op_b, 32'h01);
      check("bp_in_ready", in_ready, 32'h0);
      check("bp_op_valid", op_valid, 32'h1);
      step();
    end
    op_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 32'h1);
    step();
    check("bp_next_a", op_a, 32'hAA);
    check("bp_count", pair_count, 32'h2);
    exp_q.push_back(16'hAABB);
    in_data = 8'hBB; step();
    in_valid = 1'b0; step();
    check("bp_count2", pair_count, 32'h3);

    // Streaming 0x00..0x09 back-to-back
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      if (i % 2 == 1) exp_q.push_back({8'(i - 1), 8'(i)});
      step();
    end
    in_valid = 1'b0; step();
    check("stream_count", pair_count, 32'h8);

    // Flush mid-pair drops 0x66
    in_valid = 1'b1; in_data = 8'h55; step();
    in_data = 8'h66; flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 32'h0);
    step();
    flush = 1'b0;
    check("flush_keeps_a", op_a, 32'h55);
    exp_q.push_back(16'h7788);
    in_data = 8'h77; step();
    in_data = 8'h88; step();
    in_valid = 1'b0;
    check("flush_next_a", op_a, 32'h77);
    check("flush_next_b", op_b, 32'h88);
    step();
    check("flush_count", pair_count, 32'h9);

    // Flush during HOLD with op_ready=1: pair discarded, not counted
    op_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_valid = 1'b0;
    check("hold_valid", op_valid, 32'h1);
    flush = 1'b1; op_ready = 1'b1;
    step();
    flush = 1'b0;
    check("hold_flush_valid", op_valid, 32'h0);
    check("hold_flush_count", pair_count, 32'h9);
    check("hold_flush_b", op_b, 32'h22);

    // Clear the counter, then wrap it with 256 streamed pairs
    rst = 1'b1; step();
    rst = 1'b0;
    check("wrap_start_count", pair_count, 32'h0);
    for (int i = 0; i < 512; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      if (i % 2 == 1) exp_q.push_back({8'(i - 1), 8'(i)});
      step();
    end
    in_valid = 1'b0;
    check("wrap_count_255", pair_count, 32'hFF);
    step();
    check("wrap_count_0", pair_count, 32'h0);

    // Async reset while holding a pair
    op_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC3; step();
    in_data = 8'h3C; step();
    in_valid = 1'b0;
    check("pre_async_valid", op_valid, 32'h1);
    rst = 1'b1;
    #1;
    check("async_op_valid", op_valid, 32'h0);
    check("async_op_a", op_a, 32'h0);
    check("async_in_ready", in_ready, 32'h0);
    step();
    rst = 1'b0; op_ready = 1'b1;
    check("queue_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
